// File: rtl/ramp_sequencer.sv
// ramp_sequencer: power-up/power-down sequencer for NUM_CH signal_ramper channels.
// Define RAMP_SEQ_TIMEOUT_EN to build the ramp watchdog and the ERROR state.
module ramp_sequencer #(
    parameter int NUM_CH    = 4,
    parameter int TIMEOUT_W = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_enable_ramping,
    input  logic [NUM_CH-1:0]    cfg_channel_mask,
    input  logic [TIMEOUT_W-1:0] cfg_timeout,
    input  logic                 cmd_start,
    input  logic                 cmd_stop,
    input  logic [2*NUM_CH-1:0]  ramp_state,
    output logic [NUM_CH-1:0]    ramper_aresetn,
    output logic                 enable_ramping,
    output logic [NUM_CH-1:0]    start_ramp_down,
    output logic [2:0]           seq_state,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err
);

`ifdef RAMP_SEQ_TIMEOUT_EN
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARM       = 3'd1,
        S_RAMP_UP   = 3'd2,
        S_RUN       = 3'd3,
        S_RAMP_DOWN = 3'd4,
        S_DONE      = 3'd5,
        S_ERROR     = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARM       = 3'd1,
        S_RAMP_UP   = 3'd2,
        S_RUN       = 3'd3,
        S_RAMP_DOWN = 3'd4,
        S_DONE      = 3'd5
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic              en_q, en_d;
    logic              stop_q, stop_d;
    logic              arm_q, arm_d;
    logic              start_ok, idle_like;
    logic              all_normal, all_done;
    logic              active_d, to_error;

    assign start_ok  = cmd_start && (cfg_channel_mask != '0);
    assign seq_state = state_q;

`ifdef RAMP_SEQ_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wd_q, wd_inc;
    logic                 wd_hit, err_q;

    assign wd_inc    = wd_q + TIMEOUT_W'(1);
    assign wd_hit    = (cfg_timeout != '0) && (wd_inc == cfg_timeout);
    assign idle_like = (state_q == S_IDLE) || (state_q == S_ERROR);
    assign to_error  = (state_d == S_ERROR);

    // watchdog: restarts on any state change, counts while ramping
    always_ff @(posedge clk) begin
        if (reset)
            wd_q <= '0;
        else if (state_d != state_q)
            wd_q <= '0;
        else if (state_q == S_RAMP_UP || state_q == S_RAMP_DOWN)
            wd_q <= wd_inc;
    end

    // sticky error: set entering ERROR, cleared by an accepted start
    always_ff @(posedge clk) begin
        if (reset)
            err_q <= 1'b0;
        else if (to_error)
            err_q <= 1'b1;
        else if (start_ok && state_q == S_ERROR)
            err_q <= 1'b0;
    end

    assign timeout_err = err_q;
`else
    logic unused_timeout;

    assign unused_timeout = ^cfg_timeout;
    assign idle_like      = (state_q == S_IDLE);
    assign to_error       = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    // masked-channel status; unmasked channels never block progress
    always_comb begin
        all_normal = 1'b1;
        all_done   = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mask_q[i]) begin
                if (ramp_state[2*i +: 2] != 2'b00) all_normal = 1'b0;
                if (ramp_state[2*i +: 2] != 2'b01) all_done   = 1'b0;
            end
        end
    end

    // next state, latched configuration and pending stop
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        en_d    = en_q;
        stop_d  = stop_q;
        arm_d   = arm_q;
        if (idle_like) begin
            if (start_ok) begin
                state_d = S_ARM;
                mask_d  = cfg_channel_mask;
                en_d    = cfg_enable_ramping;
                stop_d  = 1'b0;
                arm_d   = 1'b0;
            end
        end else begin
            unique case (state_q)
                S_ARM: begin
                    if (cmd_stop) stop_d = 1'b1;
                    if (arm_q) state_d = S_RAMP_UP;
                    else       arm_d   = 1'b1;
                end
                S_RAMP_UP: begin
                    if (cmd_stop) stop_d = 1'b1;
                    if (all_normal) state_d = S_RUN;
`ifdef RAMP_SEQ_TIMEOUT_EN
                    else if (wd_hit) state_d = S_ERROR;
`endif
                end
                S_RUN: begin
                    if (stop_q || cmd_stop) state_d = S_RAMP_DOWN;
                end
                S_RAMP_DOWN: begin
                    if (all_done) state_d = S_DONE;
`ifdef RAMP_SEQ_TIMEOUT_EN
                    else if (wd_hit) state_d = S_ERROR;
`endif
                end
                S_DONE: begin
                    stop_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign active_d = state_d inside {S_RAMP_UP, S_RUN, S_RAMP_DOWN};

    // state, configuration and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            mask_q          <= '0;
            en_q            <= 1'b0;
            stop_q          <= 1'b0;
            arm_q           <= 1'b0;
            ramper_aresetn  <= '0;
            start_ramp_down <= '0;
            enable_ramping  <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            state_q         <= state_d;
            mask_q          <= mask_d;
            en_q            <= en_d;
            stop_q          <= stop_d;
            arm_q           <= arm_d;
            ramper_aresetn  <= active_d ? mask_d : '0;
            start_ramp_down <= (state_d == S_RAMP_DOWN) ? mask_d : '0;
            enable_ramping  <= (state_d != S_IDLE) && !to_error && en_d;
            busy            <= (state_d != S_IDLE);
            done            <= (state_d == S_DONE);
        end
    end

endmodule

// File: tb/tb_ramp_sequencer.sv
// tb_ramp_sequencer: vector table, directed corner sequences and
// randomized run against a behavioural model of ramp_sequencer.
module tb_ramp_sequencer;

`ifdef RAMP_SEQ_TIMEOUT_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk;
    logic        reset;
    logic        cfg_enable_ramping;
    logic [3:0]  cfg_channel_mask;
    logic [23:0] cfg_timeout;
    logic        cmd_start;
    logic        cmd_stop;
    logic [7:0]  ramp_state;
    logic [3:0]  ramper_aresetn;
    logic        enable_ramping;
    logic [3:0]  start_ramp_down;
    logic [2:0]  seq_state;
    logic        busy;
    logic        done;
    logic        timeout_err;

    int n_chk;
    int n_fail;

    ramp_sequencer #(.NUM_CH(4), .TIMEOUT_W(24)) dut (
        .clk                (clk),
        .reset              (reset),
        .cfg_enable_ramping (cfg_enable_ramping),
        .cfg_channel_mask   (cfg_channel_mask),
        .cfg_timeout        (cfg_timeout),
        .cmd_start          (cmd_start),
        .cmd_stop           (cmd_stop),
        .ramp_state         (ramp_state),
        .ramper_aresetn     (ramper_aresetn),
        .enable_ramping     (enable_ramping),
        .start_ramp_down    (start_ramp_down),
        .seq_state          (seq_state),
        .busy               (busy),
        .done               (done),
        .timeout_err        (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst, st, sp;
        logic [3:0] mask;
        logic       en;
        logic [7:0] rs;
        logic [2:0] e_st;
        logic [3:0] e_ar, e_srd;
        logic       e_en, e_busy, e_done;
    } vec_t;

    vec_t tbl[20];

    // behavioural model state (spec-level state numbers 0..6)
    int         m_st;
    int         m_arm;
    int         m_el;
    logic [3:0] m_mask;
    logic       m_en, m_stop, m_err;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] pk(input logic [2:0] s,
        input logic [3:0] ar, input logic [3:0] srd, input logic en,
        input logic b, input logic d, input logic t);
        return {s, ar, srd, en, b, d, t};
    endfunction

    function automatic logic [14:0] outs();
        return pk(seq_state, ramper_aresetn, start_ramp_down,
                  enable_ramping, busy, done, timeout_err);
    endfunction

    task automatic check(input string nm, input logic [14:0] act,
                         input logic [14:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [14:0] model_exp();
        logic [3:0] ar, srd;
        logic       en;
        ar  = (m_st >= 2 && m_st <= 4) ? m_mask : 4'h0;
        srd = (m_st == 4) ? m_mask : 4'h0;
        en  = (m_st != 0 && m_st != 6) ? m_en : 1'b0;
        return pk(3'(m_st), ar, srd, en, m_st != 0, m_st == 5, m_err);
    endfunction

    task automatic model_step(input logic rst, input logic st,
        input logic sp, input logic [3:0] cm, input logic ce,
        input logic [7:0] rs, input int to);
        bit norm, fin;
        norm = 1'b1;
        fin  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (m_mask[i]) begin
                if (rs[2*i +: 2] != 2'b00) norm = 1'b0;
                if (rs[2*i +: 2] != 2'b01) fin  = 1'b0;
            end
        end
        if (rst) begin
            m_st = 0; m_mask = 4'h0; m_en = 1'b0;
            m_stop = 1'b0; m_err = 1'b0; m_el = 0; m_arm = 0;
        end else begin
            case (m_st)
                0, 6: if (st && cm != 4'h0) begin
                    m_st = 1; m_arm = 2; m_mask = cm; m_en = ce;
                    m_stop = 1'b0; m_err = 1'b0;
                end
                1: begin
                    if (sp) m_stop = 1'b1;
                    m_arm = m_arm - 1;
                    if (m_arm == 0) begin m_st = 2; m_el = 0; end
                end
                2: begin
                    if (sp) m_stop = 1'b1;
                    m_el = m_el + 1;
                    if (norm) m_st = 3;
                    else if (WD && to != 0 && m_el == to) begin
                        m_st = 6; m_err = 1'b1;
                    end
                end
                3: if (m_stop || sp) begin m_st = 4; m_el = 0; end
                4: begin
                    m_el = m_el + 1;
                    if (fin) m_st = 5;
                    else if (WD && to != 0 && m_el == to) begin
                        m_st = 6; m_err = 1'b1;
                    end
                end
                5: begin m_stop = 1'b0; m_st = 0; end
                default: m_st = 0;
            endcase
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset = 1'b1; cfg_enable_ramping = 1'b0;
        cfg_channel_mask = 4'h0; cfg_timeout = 24'd0;
        cmd_start = 1'b0; cmd_stop = 1'b0; ramp_state = 8'hAA;

        // rst st sp mask en rs | st ar srd en busy done
        tbl[0]  = '{H,L,L,4'h0,L,8'hFA, 3'd0,4'h0,4'h0,L,L,L};
        tbl[1]  = '{L,H,L,4'h0,H,8'hFA, 3'd0,4'h0,4'h0,L,L,L};
        tbl[2]  = '{L,L,H,4'h3,H,8'hFA, 3'd0,4'h0,4'h0,L,L,L};
        tbl[3]  = '{L,H,H,4'h3,H,8'hFA, 3'd1,4'h0,4'h0,H,H,L};
        tbl[4]  = '{L,L,L,4'h0,L,8'hFA, 3'd1,4'h0,4'h0,H,H,L};
        tbl[5]  = '{L,L,L,4'h0,L,8'hFA, 3'd2,4'h3,4'h0,H,H,L};
        tbl[6]  = '{L,L,L,4'h0,L,8'hFA, 3'd2,4'h3,4'h0,H,H,L};
        tbl[7]  = '{L,L,L,4'h0,L,8'hF0, 3'd3,4'h3,4'h0,H,H,L};
        tbl[8]  = '{L,L,L,4'h0,L,8'hF0, 3'd3,4'h3,4'h0,H,H,L};
        tbl[9]  = '{L,L,H,4'h0,L,8'hF0, 3'd4,4'h3,4'h3,H,H,L};
        tbl[10] = '{L,L,H,4'h0,L,8'hF1, 3'd4,4'h3,4'h3,H,H,L};
        tbl[11] = '{L,L,L,4'h0,L,8'hF5, 3'd5,4'h0,4'h0,H,H,H};
        tbl[12] = '{L,L,L,4'h0,L,8'hF5, 3'd0,4'h0,4'h0,L,L,L};
        tbl[13] = '{L,H,L,4'h1,L,8'hFA, 3'd1,4'h0,4'h0,L,H,L};
        tbl[14] = '{L,L,H,4'h1,L,8'hFA, 3'd1,4'h0,4'h0,L,H,L};
        tbl[15] = '{L,L,L,4'h1,L,8'hFA, 3'd2,4'h1,4'h0,L,H,L};
        tbl[16] = '{L,L,L,4'h1,L,8'hF0, 3'd3,4'h1,4'h0,L,H,L};
        tbl[17] = '{L,L,L,4'h1,L,8'hF0, 3'd4,4'h1,4'h1,L,H,L};
        tbl[18] = '{L,L,L,4'h1,L,8'hF1, 3'd5,4'h0,4'h0,L,H,H};
        tbl[19] = '{L,L,L,4'h1,L,8'hF1, 3'd0,4'h0,4'h0,L,L,L};

        for (int i = 0; i < 20; i++) begin
            reset = tbl[i].rst; cmd_start = tbl[i].st;
            cmd_stop = tbl[i].sp; cfg_channel_mask = tbl[i].mask;
            cfg_enable_ramping = tbl[i].en; ramp_state = tbl[i].rs;
            cyc();
            check($sformatf("vec%0d", i), outs(),
                  pk(tbl[i].e_st, tbl[i].e_ar, tbl[i].e_srd,
                     tbl[i].e_en, tbl[i].e_busy, tbl[i].e_done, L));
        end
        reset = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0;

        // mask 0101: ready at T+10, then stop with staggered completion
        cfg_channel_mask = 4'b0101; cfg_enable_ramping = 1'b1;
        ramp_state = 8'hAA; cmd_start = 1'b1;
        cyc();
        cmd_start = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            logic [2:0] es;
            es = (k <= 2) ? 3'd1 : (k <= 10) ? 3'd2 : 3'd3;
            if (k == 10) ramp_state = 8'h88;
            check($sformatf("up_T+%0d", k), outs(),
                  pk(es, (k >= 3) ? 4'h5 : 4'h0, 4'h0, H, H, L, L));
            if (k < 11) cyc();
        end
        cmd_stop = 1'b1;
        cyc();
        cmd_stop = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            logic [14:0] e;
            if (j == 5) ramp_state = 8'h89;
            if (j == 8) ramp_state = 8'h99;
            if (j <= 8)      e = pk(3'd4, 4'h5, 4'h5, H, H, L, L);
            else if (j == 9) e = pk(3'd5, 4'h0, 4'h0, H, H, H, L);
            else             e = pk(3'd0, 4'h0, 4'h0, L, L, L, L);
            check($sformatf("down_S+%0d", j), outs(), e);
            if (j < 10) cyc();
        end

        // reset for one cycle during RAMP_DOWN
        cfg_channel_mask = 4'h3; ramp_state = 8'hFA; cmd_start = 1'b1;
        cyc();
        cmd_start = 1'b0;
        cyc();
        cyc();
        check("rst_pre_up", outs(), pk(3'd2, 4'h3, 4'h0, H, H, L, L));
        ramp_state = 8'hF0;
        cyc();
        cmd_stop = 1'b1;
        cyc();
        cmd_stop = 1'b0;
        check("rst_pre_down", outs(), pk(3'd4, 4'h3, 4'h3, H, H, L, L));
        reset = 1'b1; ramp_state = 8'hF5;
        cyc();
        reset = 1'b0;
        check("rst_abort", outs(), 15'h0);
        cyc();
        check("rst_no_done", outs(), 15'h0);

`ifdef RAMP_SEQ_TIMEOUT_EN
        // watchdog: channels stuck ramping up, limit 16
        cfg_timeout = 24'd16; cfg_channel_mask = 4'h3;
        ramp_state = 8'hAA; cmd_start = 1'b1;
        cyc();
        cmd_start = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            logic [14:0] e;
            if (k <= 2)       e = pk(3'd1, 4'h0, 4'h0, H, H, L, L);
            else if (k <= 18) e = pk(3'd2, 4'h3, 4'h0, H, H, L, L);
            else              e = pk(3'd6, 4'h0, 4'h0, L, H, L, H);
            check($sformatf("wd_T+%0d", k), outs(), e);
            if (k < 19) cyc();
        end
        for (int k = 0; k < 3; k++) begin
            cmd_stop = 1'b1;
            cyc();
            check("wd_sticky", outs(), pk(3'd6, 4'h0, 4'h0, L, H, L, H));
        end
        cmd_stop = 1'b0; cmd_start = 1'b1;
        cyc();
        cmd_start = 1'b0;
        check("wd_restart", outs(), pk(3'd1, 4'h0, 4'h0, H, H, L, L));
        cfg_timeout = 24'd0;
`endif

        // randomized run against the model
        reset = 1'b1;
        model_step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 0);
        cyc();
        reset = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            check("rand", outs(), model_exp());
            if (n % 256 == 0) cfg_timeout = 24'($urandom_range(0, 24));
            reset = ($urandom_range(0, 99) == 0);
            cmd_start = ($urandom_range(0, 7) == 0);
            cmd_stop = ($urandom_range(0, 7) == 0);
            cfg_channel_mask = 4'($urandom);
            cfg_enable_ramping = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       ramp_state = 8'h00;
                1:       ramp_state = 8'h55;
                default: ramp_state = 8'($urandom);
            endcase
            model_step(reset, cmd_start, cmd_stop, cfg_channel_mask,
                       cfg_enable_ramping, ramp_state, int'(cfg_timeout));
            cyc();
        end
        check("rand_last", outs(), model_exp());

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ramp_sequencer.md
RAMP_SEQUENCER -- requirements
Module: ramp_sequencer

Interface
REQ-001 Parameters SHALL be: NUM_CH, default 4, number of signal_ramper channels sequenced; TIMEOUT_W, default 24, width of the watchdog count.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- cfg_enable_ramping  in  1  when 0, ramp shaping is bypassed
- cfg_channel_mask  in  NUM_CH  bit i=1 means channel i takes part
- cfg_timeout  in  TIMEOUT_W  watchdog limit in cycles; 0 disables the watchdog
- cmd_start  in  1  single-cycle start pulse
- cmd_stop  in  1  single-cycle stop pulse
- ramp_state  in  2*NUM_CH  channel i state on bits [2i+1:2i]; 10=up, 00=normal, 11=down, 01=done
- ramper_aresetn  out  NUM_CH  active-low reset to each ramper
- enable_ramping  out  1  enableRamping to all rampers
- start_ramp_down  out  NUM_CH  startRampDown to each ramper
- seq_state  out  3  current sequencer state
- busy  out  1  high whenever seq_state is not IDLE
- done  out  1  one-cycle pulse on completion
- timeout_err  out  1  sticky watchdog error flag

Function
REQ-003 All outputs SHALL be registered.
REQ-004 The states and their seq_state encodings SHALL be: IDLE=0, ARM=1, RAMP_UP=2, RUN=3, RAMP_DOWN=4, DONE=5, ERROR=6.
REQ-005 In IDLE and ARM, ramper_aresetn SHALL be all 0 and start_ramp_down SHALL be all 0.
REQ-006 On cmd_start in IDLE with a nonzero cfg_channel_mask:
- the mask and cfg_enable_ramping SHALL be latched;
- seq_state SHALL be ARM one cycle later;
- seq_state SHALL be RAMP_UP after exactly 2 ARM cycles.
REQ-007 cmd_start in IDLE with mask==0 SHALL be ignored; cmd_start outside IDLE SHALL be ignored.
REQ-008 If cmd_start and cmd_stop are asserted in the same IDLE cycle, start SHALL be accepted and stop discarded; cmd_stop alone in IDLE SHALL be ignored.
REQ-009 In RAMP_UP, RUN and RAMP_DOWN:
- ramper_aresetn SHALL equal the latched mask;
- unmasked channels SHALL stay in reset.
REQ-010 enable_ramping SHALL equal the latched cfg_enable_ramping while busy, and 0 in IDLE.
REQ-011 RAMP_UP SHALL go to RUN in the first cycle in which every masked channel reports 00; unmasked channel states SHALL be ignored throughout.
REQ-012 cmd_stop in ARM or RAMP_UP SHALL set a pending-stop flag. RUN SHALL then go to RAMP_DOWN on its first cycle, so RUN lasts exactly one cycle.
REQ-013 In RUN, cmd_stop SHALL move the sequencer to RAMP_DOWN on the next cycle.
REQ-014 In RAMP_DOWN:
- start_ramp_down[i] SHALL be held at latched mask[i];
- the state SHALL go to DONE once every masked channel reports 01.
REQ-015 DONE SHALL last one cycle with done=1, clear the pending-stop flag, drive start_ramp_down to 0 and return to IDLE.
REQ-016 Repeated cmd_stop in RAMP_DOWN, DONE or ERROR SHALL have no effect.

Reset
REQ-017 While reset=1, the following SHALL hold on the next edge and persist:
- seq_state=IDLE;
- ramper_aresetn=0, start_ramp_down=0, enable_ramping=0;
- busy=0, done=0, timeout_err=0;
- pending-stop flag, latched configuration and watchdog counter cleared.
REQ-018 Reset asserted mid-sequence SHALL abort the sequence immediately, with no ramp-down and no done pulse.

Configuration
REQ-019 With macro RAMP_SEQ_TIMEOUT_EN defined, the watchdog SHALL be built in:
- a counter SHALL clear on entry to RAMP_UP or RAMP_DOWN and increment each cycle spent in those states;
- when it reaches cfg_timeout (nonzero), the state SHALL go to ERROR and timeout_err SHALL set.
REQ-020 In ERROR, ramper_aresetn, start_ramp_down and enable_ramping SHALL be 0.
REQ-021 ERROR SHALL leave only via cmd_start, which clears timeout_err and follows REQ-006; timeout_err SHALL otherwise stay set until reset.
REQ-022 Without RAMP_SEQ_TIMEOUT_EN:
- no counter and no ERROR state SHALL exist;
- timeout_err SHALL be tied to 0;
- cfg_timeout SHALL be unused.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Mask=4'b0101, cmd_start at T; ch0 and ch2 report 00 at T+10 -> ARM T+1..T+2, RAMP_UP from T+3, RUN at T+11, ramper_aresetn=0101 from T+3.
- From RUN, cmd_stop; ch0 reports 01 at +5, ch2 at +8 -> start_ramp_down=0101 from +1 until DONE; DONE at +9 with done=1; IDLE at +10.
- cmd_stop during ARM -> RAMP_UP, one cycle of RUN, then RAMP_DOWN with no further stop.
- Mask=0 with cmd_start -> stays IDLE, busy=0; cmd_start and cmd_stop in the same cycle -> sequence starts, stop discarded.
- Macro defined, cfg_timeout=16, channels held at 10 -> ERROR 16 cycles after RAMP_UP entry, timeout_err=1, outputs 0; next cmd_start clears timeout_err.
- reset=1 for one cycle in RAMP_DOWN -> all outputs at reset values next cycle, no done pulse.
